// File: rtl/qreg_pkg.sv
// Shared types for the qreg_n universal shift register.
// QREG_N_ROTATE_EN enables rotate codes 100/101; otherwise they act as hold.
package qreg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SHR  = 3'b001,
    OP_HOLD = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } qreg_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } qreg_state_t;

  // amount field must hold WIDTH itself so a full-width rotate is expressible
  function automatic int qreg_aw(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic qreg_is_burst_op(input qreg_op_t op);
`ifdef QREG_N_ROTATE_EN
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
`else
    return (op == OP_SHR) || (op == OP_SHL);
`endif
  endfunction

endpackage

// File: rtl/qreg_n_next.sv
// Combinational next-state mux for qreg_n, shared by direct and burst paths.
// Rotate arms exist only with QREG_N_ROTATE_EN.
module qreg_n_next
  import qreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  qreg_op_t         op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             si_r,
  input  logic             si_l,
  output logic [WIDTH-1:0] nq
);

  always_comb begin
    nq = q;
    case (op)
      OP_LOAD: nq = d;
      OP_SHR:  nq = {si_r, q[WIDTH-1:1]};
      OP_SHL:  nq = {q[WIDTH-2:0], si_l};
`ifdef QREG_N_ROTATE_EN
      OP_ROR:  nq = {q[0], q[WIDTH-1:1]};
      OP_ROL:  nq = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
      OP_CLR:  nq = '0;
      default: nq = q;
    endcase
  end

endmodule

// File: rtl/qreg_n.sv
// Universal shift register with counted burst engine (busy/done status).
// QREG_N_ROTATE_EN enables rotate right/left for direct and burst ops.
module qreg_n
  import qreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = qreg_aw(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] d,
  input  logic             si_r,
  input  logic             si_l,
  input  logic             start,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  qreg_state_t      state;
  qreg_op_t         op_r;
  logic [AW-1:0]    cnt;
  qreg_op_t         op_in;
  qreg_op_t         sel_op;
  logic [WIDTH-1:0] nq;
  logic             accept;

  assign op_in  = qreg_op_t'(ctrl);
  assign sel_op = (state == ST_BURST) ? op_r : op_in;
  assign accept = (state == ST_IDLE) && start && qreg_is_burst_op(op_in);

  qreg_n_next #(.WIDTH(WIDTH)) u_next (
    .op   (sel_op),
    .q    (q),
    .d    (d),
    .si_r (si_r),
    .si_l (si_l),
    .nq   (nq)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      op_r  <= OP_HOLD;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // latch edge: q untouched, steps start on the following edge
            op_r <= op_in;
            cnt  <= amount;
            if (amount != '0) begin
              state <= ST_BURST;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            q <= nq;
          end
        end
        ST_BURST: begin
          q   <= nq;
          cnt <= cnt - 1'b1;
          if (cnt == AW'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_qreg_n.sv
// Directed-vector bench for qreg_n (WIDTH=8); follows QREG_N_ROTATE_EN.
module tb_qreg_n;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    ctrl;
  logic [W-1:0]  d;
  logic          si_r, si_l, start;
  logic [AW-1:0] amount;
  logic [W-1:0]  q;
  logic          so_r, so_l, busy, done;

  int nvec = 0;
  int nerr = 0;

  qreg_n #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .ctrl   (ctrl),
    .d      (d),
    .si_r   (si_r),
    .si_l   (si_l),
    .start  (start),
    .amount (amount),
    .q      (q),
    .so_r   (so_r),
    .so_l   (so_l),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic load(input logic [7:0] v);
    ctrl = 3'b000; d = v; start = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ctrl = 3'b010; d = '0; si_r = 1'b0; si_l = 1'b0;
    start = 1'b0; amount = '0;
    tick(); tick();
    st("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.so_r", 32'(so_r), 32'd0);
    chk("reset.so_l", 32'(so_l), 32'd0);
    reset = 1'b0;

    // direct ops
    load(8'hA5);
    st("load", 8'hA5, 1'b0, 1'b0);
    chk("load.so_r", 32'(so_r), 32'd1);
    chk("load.so_l", 32'(so_l), 32'd1);
    ctrl = 3'b001; si_r = 1'b1; tick();
    chk("shr", 32'(q), 32'hD2);
    ctrl = 3'b011; si_l = 1'b0; tick();
    chk("shl", 32'(q), 32'hA4);
    ctrl = 3'b110; tick();
    chk("clr", 32'(q), 32'h00);
    load(8'h3C);
    ctrl = 3'b010; tick();
    chk("hold", 32'(q), 32'h3C);
    ctrl = 3'b111; tick();
    chk("rsvd", 32'(q), 32'h3C);
    ctrl = 3'b000; d = 8'h11; start = 1'b1; amount = 4'd3; tick();
    st("start_on_load", 8'h11, 1'b0, 1'b0);
    start = 1'b0;

`ifdef QREG_N_ROTATE_EN
    load(8'h81);
    ctrl = 3'b101; tick();
    chk("rol_direct", 32'(q), 32'h03);
    load(8'h81);
    ctrl = 3'b100; start = 1'b1; amount = 4'd3; tick();
    st("ror_e0", 8'h81, 1'b1, 1'b0);
    start = 1'b0; ctrl = 3'b000; d = 8'hFF; tick();
    st("ror_e1", 8'hC0, 1'b1, 1'b0);
    tick();
    st("ror_e2", 8'h60, 1'b1, 1'b0);
    tick();
    st("ror_e3", 8'h30, 1'b0, 1'b1);
    ctrl = 3'b010; tick();
    st("ror_after", 8'h30, 1'b0, 1'b0);
    load(8'h5A);
    ctrl = 3'b101; start = 1'b1; amount = 4'd8; tick();
    start = 1'b0; ctrl = 3'b010;
    for (int i = 0; i < 8; i++) tick();
    st("rol8", 8'h5A, 1'b0, 1'b1);
`else
    load(8'h81);
    ctrl = 3'b100; tick();
    chk("ror_off", 32'(q), 32'h81);
    ctrl = 3'b101; start = 1'b1; amount = 4'd3; tick();
    st("rol_start_off", 8'h81, 1'b0, 1'b0);
    start = 1'b0; ctrl = 3'b010; tick();
    st("rol_start_off2", 8'h81, 1'b0, 1'b0);
`endif

    // burst shift right with inputs toggling during busy
    load(8'hF0);
    ctrl = 3'b001; si_r = 1'b0; start = 1'b1; amount = 4'd2; tick();
    st("shr_e0", 8'hF0, 1'b1, 1'b0);
    ctrl = 3'b000; d = 8'hFF; amount = 4'd7; tick();
    st("shr_e1", 8'h78, 1'b1, 1'b0);
    ctrl = 3'b110; start = 1'b0; tick();
    st("shr_e2", 8'h3C, 1'b0, 1'b1);
    // start in done cycle with amount 0: accepted, no shift, done again
    ctrl = 3'b011; start = 1'b1; amount = 4'd0; tick();
    st("amt0", 8'h3C, 1'b0, 1'b1);
    ctrl = 3'b010; start = 1'b0; tick();
    st("amt0_after", 8'h3C, 1'b0, 1'b0);

    // serial-in sampled live each burst step
    ctrl = 3'b011; start = 1'b1; amount = 4'd2; tick();
    st("shl_e0", 8'h3C, 1'b1, 1'b0);
    start = 1'b0; si_l = 1'b1; tick();
    st("shl_e1", 8'h79, 1'b1, 1'b0);
    si_l = 1'b0; tick();
    st("shl_e2", 8'hF2, 1'b0, 1'b1);

    // reset aborts burst
    load(8'hFF);
    ctrl = 3'b001; si_r = 1'b0; start = 1'b1; amount = 4'd5; tick();
    start = 1'b0; tick();
    chk("abort_s1", 32'(q), 32'h7F);
    tick();
    chk("abort_s2", 32'(q), 32'h3F);
    reset = 1'b1; tick();
    st("abort_rst", 8'h00, 1'b0, 1'b0);
    reset = 1'b0; ctrl = 3'b010; tick();
    st("abort_after", 8'h00, 1'b0, 1'b0);
    tick();
    st("abort_after2", 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
